// File: rtl/mux_nto1_arbitrado.sv
// N-to-1 registered multiplexer with per-channel valid/ready inputs and a
// single valid/ready output register. Channel choice is either an explicit
// selector (i_modo = 0) or round-robin among requesting channels (i_modo = 1).
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. Valid never depends on ready; ready (o_listo) is
// combinational from i_listo, i_valido, i_modo, i_selector and the pointer.
// The output register accepts a new word when it is empty or being drained
// in the same cycle, so a continuous stream moves one word per cycle.
module mux_nto1_arbitrado #(
  parameter int N_CANALES = 4,
  parameter int ANCHO     = 32,
  localparam int ANCHO_SEL = (N_CANALES > 1) ? $clog2(N_CANALES) : 1
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_modo,
  input  logic [ANCHO_SEL-1:0]       i_selector,
  input  logic [N_CANALES-1:0]       i_valido,
  input  logic [N_CANALES*ANCHO-1:0] i_datos,
  output logic [N_CANALES-1:0]       o_listo,
  output logic                       o_valido,
  output logic [ANCHO-1:0]           o_dato,
  output logic [ANCHO_SEL-1:0]       o_canal,
  input  logic                       i_listo
);

  // Round-robin pointer: channel with highest priority on the next mode-1 grant.
  logic [ANCHO_SEL-1:0] puntero;
  logic                 carga;
  logic                 hay_grant;
  logic [ANCHO_SEL-1:0] canal_grant;
  logic [ANCHO_SEL-1:0] puntero_sig;
  int                   idx;

  // Register may load when empty or when its word leaves this cycle; never in reset.
  assign carga = i_reset && (!o_valido || i_listo);

  // Grant selection: explicit selector or first requester at/after the pointer.
  always_comb begin
    hay_grant   = 1'b0;
    canal_grant = '0;
    idx         = 0;
    if (!i_modo) begin
      if ((int'(i_selector) < N_CANALES) && i_valido[i_selector]) begin
        hay_grant   = 1'b1;
        canal_grant = i_selector;
      end
    end else begin
      for (int k = 0; k < N_CANALES; k++) begin
        idx = (int'(puntero) + k) % N_CANALES;
        if (!hay_grant && i_valido[idx]) begin
          hay_grant   = 1'b1;
          canal_grant = ANCHO_SEL'(idx);
        end
      end
    end
  end

  // One-hot ready back to the granted channel only when the register can load.
  always_comb begin
    o_listo = '0;
    for (int k = 0; k < N_CANALES; k++) begin
      o_listo[k] = carga && hay_grant && (canal_grant == ANCHO_SEL'(k));
    end
  end

  // Pointer moves one past the granted channel, wrapping at the last channel.
  always_comb begin
    puntero_sig = '0;
    if (int'(canal_grant) != N_CANALES - 1) begin
      puntero_sig = canal_grant + ANCHO_SEL'(1);
    end
  end

  // Output register and pointer; reset discards any held word.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_valido <= 1'b0;
      o_dato   <= '0;
      o_canal  <= '0;
      puntero  <= '0;
    end else if (carga && hay_grant) begin
      o_valido <= 1'b1;
      o_dato   <= i_datos[canal_grant*ANCHO +: ANCHO];
      o_canal  <= canal_grant;
      if (i_modo) begin
        puntero <= puntero_sig;
      end
    end else if (o_valido && i_listo) begin
      o_valido <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_arbitrado.sv
// Directed bench for mux_nto1_arbitrado (N_CANALES = 4, ANCHO = 32).
module tb_mux_nto1_arbitrado;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  // Clock / reset block
  logic            clk = 1'b0;
  logic            rst_n;
  logic            modo;
  logic [SW-1:0]   selector;
  logic [N-1:0]    valido;
  logic [N*W-1:0]  datos;
  logic [N-1:0]    listo_out;
  logic            valido_out;
  logic [W-1:0]    dato_out;
  logic [SW-1:0]   canal_out;
  logic            listo_in;

  always #5 clk = ~clk;

  mux_nto1_arbitrado #(.N_CANALES(N), .ANCHO(W)) dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_modo    (modo),
    .i_selector(selector),
    .i_valido  (valido),
    .i_datos   (datos),
    .o_listo   (listo_out),
    .o_valido  (valido_out),
    .o_dato    (dato_out),
    .o_canal   (canal_out),
    .i_listo   (listo_in)
  );

  int checks = 0;
  int errors = 0;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_default_data();
    for (int k = 0; k < N; k++) datos[k*W +: W] = 32'hA0 + 32'(k);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d, input logic [SW-1:0] c);
    chk({tag, "_valido"}, 64'(valido_out), 64'(v));
    chk({tag, "_dato"},   64'(dato_out),   64'(d));
    chk({tag, "_canal"},  64'(canal_out),  64'(c));
  endtask

  initial begin
    // Reset held two edges with all channels requesting and sink ready.
    rst_n    = 1'b0;
    modo     = 1'b1;
    selector = '0;
    valido   = 4'b1111;
    listo_in = 1'b1;
    load_default_data();
    step();
    step();
    chk_out("reset", 1'b0, 32'h0, 2'd0);
    chk("reset_listo", 64'(listo_out), 64'h0);

    // Release: mode 1 full load, grants 0,1,2,3,0,1 back to back.
    rst_n = 1'b1;
    settle();
    chk("rel_listo", 64'(listo_out), 64'b0001);
    step(); chk_out("rr0", 1'b1, 32'hA0, 2'd0);
    step(); chk_out("rr1", 1'b1, 32'hA1, 2'd1);
    step(); chk_out("rr2", 1'b1, 32'hA2, 2'd2);
    step(); chk_out("rr3", 1'b1, 32'hA3, 2'd3);
    step(); chk_out("rr4", 1'b1, 32'hA0, 2'd0);
    step(); chk_out("rr5", 1'b1, 32'hA1, 2'd1);
    // Pointer now 2.

    // Mode 0: explicit selector 2.
    modo     = 1'b0;
    selector = 2'd2;
    settle();
    chk("m0_listo", 64'(listo_out), 64'b0100);
    step(); chk_out("m0_load", 1'b1, 32'hA2, 2'd2);
    valido = 4'b1011;
    settle();
    chk("m0_nogrant_listo", 64'(listo_out), 64'h0);
    step(); chk_out("m0_drain", 1'b0, 32'hA2, 2'd2);

    // Back to mode 1: pointer must still be 2 after mode-0 traffic.
    modo   = 1'b1;
    valido = 4'b1111;
    settle();
    chk("m1_ptr_kept", 64'(listo_out), 64'b0100);

    // Sparse requests 1010 from pointer 2: grants 3,1,3.
    valido = 4'b1010;
    settle();
    chk("sp_listo", 64'(listo_out), 64'b1000);
    step(); chk_out("sp0", 1'b1, 32'hA3, 2'd3);
    step(); chk_out("sp1", 1'b1, 32'hA1, 2'd1);
    step(); chk_out("sp2", 1'b1, 32'hA3, 2'd3);
    // After grant to 3 the pointer wraps to 0.
    valido = 4'b0001;
    settle();
    chk("wrap_listo", 64'(listo_out), 64'b0001);
    step(); chk_out("wrap", 1'b1, 32'hA0, 2'd0);
    // Nothing requesting: register drains, data held.
    valido = 4'b0000;
    step(); chk_out("idle_drain", 1'b0, 32'hA0, 2'd0);

    // Backpressure: load 0x55 from channel 1 (pointer 1 -> 2).
    datos[1*W +: W] = 32'h55;
    valido = 4'b0010;
    step(); chk_out("bp_load", 1'b1, 32'h55, 2'd1);
    load_default_data();
    valido   = 4'b1111;
    listo_in = 1'b0;
    settle();
    chk("bp_listo", 64'(listo_out), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("bp_hold", 1'b1, 32'h55, 2'd1);
      chk("bp_hold_listo", 64'(listo_out), 64'h0);
    end
    listo_in = 1'b1;
    settle();
    chk("bp_release_listo", 64'(listo_out), 64'b0100);
    step(); chk_out("bp_reload", 1'b1, 32'hA2, 2'd2);

    // Reset mid-stream: pointer 3 -> grants 3,0,1,2 then reset.
    step(); chk_out("ms3", 1'b1, 32'hA3, 2'd3);
    step(); chk_out("ms0", 1'b1, 32'hA0, 2'd0);
    step(); chk_out("ms1", 1'b1, 32'hA1, 2'd1);
    step(); chk_out("ms2", 1'b1, 32'hA2, 2'd2);
    rst_n = 1'b0;
    settle();
    chk("ms_rst_listo", 64'(listo_out), 64'h0);
    step(); chk_out("ms_rst", 1'b0, 32'h0, 2'd0);
    rst_n = 1'b1;
    settle();
    chk("ms_rel_listo", 64'(listo_out), 64'b0001);
    step(); chk_out("ms_first", 1'b1, 32'hA0, 2'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
